// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: shadows a packed nibble vector,
// scans DIGITS positions and adds hex/decimal decode, leading-zero blanking, dp and blink.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_en,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

    logic [4*DIGITS-1:0] shadow_value;
    logic [DIGITS-1:0]   shadow_dp;
    logic [PW-1:0]       presc;
    logic [IW-1:0]       index;
    logic [BW-1:0]       blink_cnt;
    logic                blink_phase;

    logic                slot_end;
    logic                frame_wrap;
    logic [DIGITS-1:0]   lz_zero;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blink;
    logic                cur_lz;
    logic [DIGITS-1:0]   an_next;
    logic [6:0]          seg_next;
    logic                seg_dp_next;

    function automatic logic [6:0] decode_nibble(input logic [3:0] nib, input logic hex);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        if (!hex && nib >= 4'hA) begin
            s = 7'b1111111;
        end
        return s;
    endfunction

    assign slot_end   = (presc == PRESC_TC);
    assign frame_wrap = slot_end && (index == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            presc        <= '0;
            index        <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
        end else begin
            if (load) begin
                shadow_value <= value;
                shadow_dp    <= dp;
            end
            if (slot_end) begin
                presc <= '0;
                index <= frame_wrap ? '0 : index + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
            if (frame_wrap) begin
                if (blink_cnt == BLINK_TC) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

    // lz_zero[k]: every shadow digit from k up to the top is zero (digit 0 never qualifies)
    always_comb begin
        lz_zero = '0;
        for (int k = 1; k < DIGITS; k++) begin
            lz_zero[k] = 1'b1;
            for (int j = k; j < DIGITS; j++) begin
                if (shadow_value[4*j +: 4] != 4'd0) begin
                    lz_zero[k] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        cur_nib   = 4'd0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        an_next   = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (index == IW'(k)) begin
                cur_nib    = shadow_value[4*k +: 4];
                cur_dp     = shadow_dp[k];
                cur_blink  = blink_en[k];
                cur_lz     = lz_zero[k];
                an_next[k] = 1'b0;
            end
        end
    end

    always_comb begin
        seg_next    = decode_nibble(cur_nib, hex_mode);
        seg_dp_next = ~cur_dp;
        if (blank_lz && cur_lz) begin
            seg_next = 7'b1111111;
        end
        if (cur_blink && blink_phase) begin
            seg_next    = 7'b1111111;
            seg_dp_next = 1'b1;
        end
    end

    // Anode and segments register together so a pair is never mismatched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg        <= 7'b1111111;
            seg_dp     <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            seg_dp     <= seg_dp_next;
            an         <= an_next;
            frame_done <= frame_wrap;
        end
    end

endmodule
